// File: rtl/scene_loader_pkg.sv
// Shared definitions for the scene loader: buffer geometry, frame sync byte,
// loader FSM states and error codes.
package scene_loader_pkg;

  localparam int SCENE_BUFFER_WIDTH = 32;
  localparam int SCENE_BUFFER_DEPTH = 64;

  localparam logic [7:0] SCENE_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } loader_state_e;

  localparam logic [1:0] ERR_COUNT    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/scene_loader_byte_packer.sv
// Assembles little-endian bytes into one object word; presents the finished
// word with a one-cycle strobe the cycle after its last byte.
module scene_loader_byte_packer #(
  parameter int WIDTH         = 20,
  parameter int BYTES_PER_OBJ = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic             last_byte,
  output logic [WIDTH-1:0] word,
  output logic             strobe
);

  localparam int IDX_W = (BYTES_PER_OBJ > 1) ? $clog2(BYTES_PER_OBJ) : 1;
  localparam int ACC_W = BYTES_PER_OBJ * 8;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             strobe_q, strobe_d;

  assign last_byte = byte_valid && !clr && (idx_q == IDX_W'(BYTES_PER_OBJ - 1));
  assign word      = word_q;
  assign strobe    = strobe_q;

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    word_d   = word_q;
    strobe_d = 1'b0;
    if (clr) begin
      idx_d = '0;
    end else if (byte_valid) begin
      for (int k = 0; k < BYTES_PER_OBJ; k++) begin
        if (idx_q == IDX_W'(k)) begin
          acc_d[k*8 +: 8] = byte_in;
        end else begin
          acc_d[k*8 +: 8] = acc_q[k*8 +: 8];
        end
      end
      if (last_byte) begin
        idx_d    = '0;
        word_d   = acc_d[WIDTH-1:0];  // bits beyond WIDTH in the last byte are dropped
        strobe_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      acc_q    <= '0;
      word_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      word_q   <= word_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: rtl/scene_loader.sv
// Frame parser that loads a scene into BRAM port A: validates count,
// checksum and inter-byte timeout, and publishes the loaded object count.
module scene_loader
  import scene_loader_pkg::*;
#(
  parameter int SCENE_WIDTH    = SCENE_BUFFER_WIDTH,
  parameter int SCENE_DEPTH    = SCENE_BUFFER_DEPTH,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     data_in,
  input  logic                           data_valid,
  output logic                           wr_en,
  output logic [$clog2(SCENE_DEPTH)-1:0] wr_addr,
  output logic [SCENE_WIDTH-1:0]         wr_data,
  output logic [7:0]                     num_objs,
  output logic                           scene_valid,
  output logic                           busy,
  output logic                           load_done,
  output logic                           load_err,
  output logic [1:0]                     err_code
);

  localparam int BYTES_PER_OBJ = (SCENE_WIDTH + 7) / 8;
  localparam int ADDR_W        = $clog2(SCENE_DEPTH);
  localparam int TMO_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  loader_state_e     state_q, state_d;
  logic [7:0]        chk_q, chk_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        obj_q, obj_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        num_objs_q, num_objs_d;
  logic              scene_valid_q, scene_valid_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic pk_valid_s, pk_clr_s, pk_last_s;

  assign pk_valid_s = data_valid && (state_q == ST_PAYLOAD);
  assign pk_clr_s   = (state_q == ST_COUNT);

  scene_loader_byte_packer #(
    .WIDTH         (SCENE_WIDTH),
    .BYTES_PER_OBJ (BYTES_PER_OBJ)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr_s),
    .byte_valid (pk_valid_s),
    .byte_in    (data_in),
    .last_byte  (pk_last_s),
    .word       (wr_data),
    .strobe     (wr_en)
  );

  assign wr_addr     = wr_addr_q;
  assign num_objs    = num_objs_q;
  assign scene_valid = scene_valid_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign err_code    = err_code_q;

  always_comb begin
    state_d       = state_q;
    chk_d         = chk_q;
    tmo_d         = tmo_q;
    cnt_d         = cnt_q;
    obj_d         = obj_q;
    wr_addr_d     = wr_addr_q;
    num_objs_d    = num_objs_q;
    scene_valid_d = scene_valid_q;
    load_done_d   = 1'b0;
    load_err_d    = 1'b0;
    err_code_d    = err_code_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (data_valid && (data_in == SCENE_SYNC_BYTE)) begin
          state_d       = ST_COUNT;
          chk_d         = 8'h00;
          scene_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // Inside a frame a byte always wins over the timeout in the same cycle.
        if (data_valid) begin
          tmo_d = '0;
          case (state_q)
            ST_COUNT: begin
              if ((data_in != 8'd0) && (data_in <= 8'(SCENE_DEPTH))) begin
                state_d = ST_PAYLOAD;
                cnt_d   = data_in;
                obj_d   = 8'd0;
                chk_d   = chk_q ^ data_in;
              end else begin
                state_d    = ST_IDLE;
                load_err_d = 1'b1;
                err_code_d = ERR_COUNT;
              end
            end
            ST_PAYLOAD: begin
              chk_d = chk_q ^ data_in;
              if (pk_last_s) begin
                wr_addr_d = obj_q[ADDR_W-1:0];
                obj_d     = obj_q + 8'd1;
                if (obj_q == (cnt_q - 8'd1)) begin
                  state_d = ST_CHECK;
                end else begin
                  state_d = ST_PAYLOAD;
                end
              end else begin
                state_d = ST_PAYLOAD;
              end
            end
            ST_CHECK: begin
              state_d = ST_IDLE;
              if (data_in == chk_q) begin
                load_done_d   = 1'b1;
                scene_valid_d = 1'b1;
                num_objs_d    = cnt_q;
              end else begin
                load_err_d = 1'b1;
                err_code_d = ERR_CHECKSUM;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else if (tmo_q >= TMO_LAST) begin
          state_d    = ST_IDLE;
          tmo_d      = '0;
          load_err_d = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      chk_q         <= 8'h00;
      tmo_q         <= '0;
      cnt_q         <= 8'd0;
      obj_q         <= 8'd0;
      wr_addr_q     <= '0;
      num_objs_q    <= 8'd0;
      scene_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      chk_q         <= chk_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      obj_q         <= obj_d;
      wr_addr_q     <= wr_addr_d;
      num_objs_q    <= num_objs_d;
      scene_valid_q <= scene_valid_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
      err_code_q    <= err_code_d;
    end
  end

endmodule

// File: tb/tb_scene_loader.sv
// Scoreboard bench for scene_loader: directed frames push expected writes and
// completion events; a negedge monitor pops and compares them.
module tb_scene_loader;

  localparam int W = 20;
  localparam int D = 4;
  localparam int T = 16;

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         data_valid = 1'b0;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [7:0]   num_objs;
  logic         scene_valid;
  logic         busy;
  logic         load_done;
  logic         load_err;
  logic [1:0]   err_code;

  scene_loader #(
    .SCENE_WIDTH    (W),
    .SCENE_DEPTH    (D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .num_objs    (num_objs),
    .scene_valid (scene_valid),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   kind;
    logic [1:0]   addr;
    logic [W-1:0] data;
    logic [1:0]   code;
    logic [7:0]   nobj;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   fb[$];
  logic [W-1:0] fw[$];
  logic [7:0]   m_nobj = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic take(input logic [1:0] kind, output exp_t e, output bit ok);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      ok = 1'b0;
      e  = '0;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
      check("event_kind", 32'(kind), 32'(e.kind));
    end
  endtask

  // Monitor: every output event consumes the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n) begin
      if (wr_en) begin
        take(K_WR, e, ok);
        if (ok && e.kind == K_WR) begin
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (load_done) begin
        take(K_DONE, e, ok);
        if (ok && e.kind == K_DONE) begin
          check("done_num_objs", 32'(num_objs), 32'(e.nobj));
          check("done_scene_valid", 32'(scene_valid), 32'd1);
        end
      end
      if (load_err) begin
        take(K_ERR, e, ok);
        if (ok && e.kind == K_ERR) begin
          check("err_code", 32'(err_code), 32'(e.code));
          check("err_scene_valid", 32'(scene_valid), 32'd0);
          check("err_num_objs", 32'(num_objs), 32'(e.nobj));
        end
      end
    end
  end

  task automatic push(input logic [1:0] kind, input logic [1:0] addr, input logic [W-1:0] data,
                      input logic [1:0] code, input logic [7:0] nobj);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.nobj = nobj;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Sends fb (SYNC, COUNT, payload) plus a checksum; fw holds the hand-computed words.
  task automatic run_frame(input bit flip);
    logic [7:0] chk;
    chk = 8'h00;
    for (int i = 1; i < fb.size(); i++) chk = chk ^ fb[i];
    if (flip) chk = chk ^ 8'h01;
    for (int i = 0; i < fw.size(); i++) push(K_WR, 2'(i), fw[i], 2'd0, 8'd0);
    if (flip) begin
      push(K_ERR, 2'd0, '0, 2'd3, m_nobj);
    end else begin
      push(K_DONE, 2'd0, '0, 2'd0, fb[1]);
      m_nobj = fb[1];
    end
    send_byte(fb[0]);
    check("sync_clears_valid", 32'(scene_valid), 32'd0);
    for (int i = 1; i < fb.size(); i++) send_byte(fb[i]);
    send_byte(chk);
  endtask

  task automatic bad_count(input logic [7:0] n);
    push(K_ERR, 2'd0, '0, 2'd1, m_nobj);
    send_byte(8'hA5);
    send_byte(n);
    drain("bad_count_drain");
  endtask

  task automatic check_all_zero(input string name);
    check(name, {21'd0, wr_en, wr_addr, num_objs}, 32'd0);
    check(name, {27'd0, scene_valid, busy, load_done, load_err, 1'b0}, 32'd0);
    check(name, 32'(err_code), 32'd0);
    check(name, 32'(wr_data), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    idle(2);

    // Noise in IDLE is ignored.
    send_byte(8'h00); idle(1);
    send_byte(8'hFF); idle(1);
    send_byte(8'h5A); idle(2);
    check("noise_busy", 32'(busy), 32'd0);

    // Good two-object frame.
    fb = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h3F, 8'h44, 8'h55, 8'hF6};
    fw = '{20'hF2211, 20'h65544};
    run_frame(1'b0);
    drain("good_drain");
    check("good_valid", 32'(scene_valid), 32'd1);
    check("good_num_objs", 32'(num_objs), 32'd2);

    bad_count(8'h00);
    bad_count(8'h05);
    check("bad_count_valid", 32'(scene_valid), 32'd0);

    // Four-object frame with corrupted checksum: writes issue, count unchanged.
    fb = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    fw = '{20'h30201, 20'h60504, 20'h90807, 20'hC0B0A};
    run_frame(1'b1);
    drain("chk_err_drain");
    check("chk_err_num_objs", 32'(num_objs), 32'd2);

    // Timeout mid-object.
    push(K_ERR, 2'd0, '0, 2'd2, m_nobj);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hAA);
    idle(15);
    check("timeout_busy_before", 32'(busy), 32'd1);
    idle(3);
    check("timeout_busy", 32'(busy), 32'd0);
    drain("timeout_drain");

    // Full-depth frame loads; error code is held across good frames.
    run_frame(1'b0);
    drain("depth_drain");
    check("depth_num_objs", 32'(num_objs), 32'd4);
    check("err_code_held", 32'(err_code), 32'd2);

    // SYNC value inside payload is data.
    fb = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5};
    fw = '{20'h5A5A5};
    run_frame(1'b0);
    drain("sync_data_drain");

    // Reset mid-payload.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    m_nobj = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    fb = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h3F, 8'h44, 8'h55, 8'hF6};
    fw = '{20'hF2211, 20'h65544};
    run_frame(1'b0);
    // Back-to-back second frame with zero gap.
    fb = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'hEF};
    fw = '{20'hFCDAB};
    run_frame(1'b0);
    drain("b2b_drain");
    check("b2b_num_objs", 32'(num_objs), 32'd1);
    check("b2b_valid", 32'(scene_valid), 32'd1);

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
